// File: rtl/cipher_loader_pkg.sv
// Shared types for the AES-128 byte-stream loader and the cipher it feeds.
// Matrices are indexed [word][byte], so stream byte n lands in [n/4][n%4].
package cipher_loader_pkg;

  localparam int BYTE_W      = 8;
  localparam int BLOCK_BYTES = 16;

  typedef logic [0:3][0:3][BYTE_W-1:0] byte_matrix_t;
  typedef logic [3:0]                  byte_idx_t;

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_DATA,
    PRESENT
  } loader_state_t;

  function automatic logic is_last_byte(byte_idx_t idx);
    return idx == byte_idx_t'(BLOCK_BYTES - 1);
  endfunction

endpackage

// File: rtl/cipher_block_loader_if.sv
// Byte-stream input and matrix-present output of the cipher loader.
// slave = loader side, master = producer/consumer side.
interface cipher_block_loader_if;
  import cipher_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_byte;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  byte_matrix_t      data;
  byte_matrix_t      key;

  modport slave (
    input  in_valid, in_byte, abort, out_ready,
    output in_ready, out_valid, data, key
  );

  modport master (
    output in_valid, in_byte, abort, out_ready,
    input  in_ready, out_valid, data, key
  );

endinterface

// File: rtl/byte_matrix_writer.sv
// 4x4 byte register written one element per cycle; idx[3:2] selects the word,
// idx[1:0] the byte within it.
module byte_matrix_writer
  import cipher_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  byte_idx_t         idx_i,
  input  logic [BYTE_W-1:0] byte_i,
  output byte_matrix_t      mat_o
);

  byte_matrix_t mat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   mat_q <= '0;
    else if (we_i) mat_q[idx_i[3:2]][idx_i[1:0]] <= byte_i;
  end

  assign mat_o = mat_q;

endmodule

// File: rtl/cipher_block_loader.sv
// Streams 16 key bytes then 16 data bytes into 4x4 matrices and holds them for the cipher.
// Optional `KEY_REUSE_EN: after the first key, later blocks carry data bytes only.
module cipher_block_loader
  import cipher_loader_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cipher_block_loader_if.slave  bus
);

  localparam int NUM_MATS = 2;  // 0: key, 1: data

  loader_state_t state_q, state_d;
  byte_idx_t     cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  loader_state_t resume_st;

  logic                accept;
  logic [NUM_MATS-1:0] we;
  byte_matrix_t        mat [NUM_MATS];

`ifdef KEY_REUSE_EN
  logic key_loaded_q, key_loaded_d;
  assign resume_st = key_loaded_q ? LOAD_DATA : LOAD_KEY;
`else
  assign resume_st = LOAD_KEY;
`endif

  assign accept = bus.in_valid && in_ready_q;

  // An abort drops the byte offered in the same cycle.
  assign we[0] = accept && !bus.abort && (state_q == LOAD_KEY);
  assign we[1] = accept && !bus.abort && (state_q == LOAD_DATA);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
`ifdef KEY_REUSE_EN
    key_loaded_d = key_loaded_q;
`endif
    if (bus.abort) begin
      state_d     = resume_st;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_KEY: if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (is_last_byte(cnt_q)) begin
            state_d = LOAD_DATA;
            cnt_d   = '0;
`ifdef KEY_REUSE_EN
            key_loaded_d = 1'b1;
`endif
          end
        end
        LOAD_DATA: if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (is_last_byte(cnt_q)) begin
            state_d     = PRESENT;
            cnt_d       = '0;
            out_valid_d = 1'b1;
          end
        end
        PRESENT: if (bus.out_ready) begin
          state_d     = resume_st;
          out_valid_d = 1'b0;
        end
        default: begin
          state_d     = LOAD_KEY;
          cnt_d       = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
    // Registered decode of the next state keeps out_ready off the in_ready path.
    in_ready_d = (state_d != PRESENT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= LOAD_KEY;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef KEY_REUSE_EN
      key_loaded_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef KEY_REUSE_EN
      key_loaded_q <= key_loaded_d;
`endif
    end
  end

  for (genvar m = 0; m < NUM_MATS; m++) begin : g_mat
    byte_matrix_writer u_wr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (we[m]),
      .idx_i  (cnt_q),
      .byte_i (bus.in_byte),
      .mat_o  (mat[m])
    );
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.key       = mat[0];
  assign bus.data      = mat[1];

endmodule

// File: tb/tb_cipher_block_loader.sv
// Directed bench for cipher_block_loader with a block scoreboard and an AES-128 reference.
module tb_cipher_block_loader;
  import cipher_loader_pkg::*;

  typedef struct {
    byte_matrix_t key;
    byte_matrix_t data;
  } blk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   hs = 0;
  int   n_total = 0;
  int   n_pass = 0;
  blk_t sb[$];

  cipher_block_loader_if ifc ();

  cipher_block_loader dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ifc.out_valid && ifc.out_ready) hs <= hs + 1;

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [7:0] r;
    r = (x << k) | (x >> (8 - k));
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, b;
    r = 8'h01; b = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gm(r, b);
      b = gm(b, b);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [0:15][7:0] aes128(input logic [0:15][7:0] k, input logic [0:15][7:0] pt);
    logic [0:15][7:0] s, t, rk;
    logic [7:0] rc, a0, a1, a2, a3, w0, w1, w2, w3;
    rk = k; s = pt ^ k; rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      w0 = sbox(rk[13]) ^ rc; w1 = sbox(rk[14]); w2 = sbox(rk[15]); w3 = sbox(rk[12]);
      rk[0] = rk[0] ^ w0; rk[1] = rk[1] ^ w1; rk[2] = rk[2] ^ w2; rk[3] = rk[3] ^ w3;
      for (int j = 4; j < 16; j++) rk[j] = rk[j] ^ rk[j-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      s = s ^ rk;
    end
    return s;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int guard;
    if (gaps) begin
      while ($urandom_range(1) == 1) begin
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    ifc.in_valid = 1'b1;
    ifc.in_byte  = b;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      acc = ifc.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) check("send_timeout", 128'd0, 128'd1);
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] kv, input logic [127:0] dv,
                            input bit with_key, input bit gaps);
    logic [0:15][7:0] kb, db;
    blk_t e;
    kb = kv; db = dv;
    e.key = kv; e.data = dv;
    sb.push_back(e);
    if (with_key) for (int i = 0; i < 16; i++) send_byte(kb[i], gaps);
    for (int i = 0; i < 16; i++) send_byte(db[i], gaps);
  endtask

  task automatic wait_present(input string tag);
    int g;
    g = 0;
    while (!ifc.out_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!ifc.out_valid) check({tag, "_present_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic consume(input string tag, input int hold);
    blk_t e;
    int hs0;
    wait_present(tag);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 128'd0, 128'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_key"}, ifc.key, e.key);
    check({tag, "_data"}, ifc.data, e.data);
    check({tag, "_cipher"}, aes128(ifc.key, ifc.data), aes128(e.key, e.data));
    check({tag, "_in_ready_present"}, 128'(ifc.in_ready), 128'd0);
    for (int i = 0; i < hold; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_byte  = 8'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_key"}, ifc.key, e.key);
      check({tag, "_hold_data"}, ifc.data, e.data);
      check({tag, "_hold_ov"}, 128'(ifc.out_valid), 128'd1);
      check({tag, "_hold_in_ready"}, 128'(ifc.in_ready), 128'd0);
    end
    ifc.in_valid  = 1'b0;
    hs0 = hs;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    check({tag, "_ov_drop"}, 128'(ifc.out_valid), 128'd0);
    check({tag, "_in_ready_back"}, 128'(ifc.in_ready), 128'd1);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_one_handshake"}, 128'(hs - hs0), 128'd1);
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [0:15][7:0] kb, db, d2b, d3b;
    logic [127:0] k2, d2, k3, d3, k4, d4, k5, d5, k6, d6;
    blk_t e;
    int start;

    ifc.in_valid = 1'b0; ifc.in_byte = '0; ifc.abort = 1'b0; ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(ifc.out_valid), 128'd0);
    check("rst_in_ready", 128'(ifc.in_ready), 128'd1);
    check("rst_key", ifc.key, 128'd0);
    check("rst_data", ifc.data, 128'd0);
    rst_n = 1'b1;

    // 1: FIPS-197 C.1 back-to-back, out_valid 32 edges after the first byte
    kb = K1; db = D1;
    e.key = K1; e.data = D1;
    sb.push_back(e);
    start = cyc;
    for (int i = 0; i < 16; i++) send_byte(kb[i], 1'b0);
    for (int i = 0; i < 15; i++) send_byte(db[i], 1'b0);
    check("t1_ov_before_last", 128'(ifc.out_valid), 128'd0);
    send_byte(db[15], 1'b0);
    check("t1_ov_after_last", 128'(ifc.out_valid), 128'd1);
    check("t1_latency", 128'(cyc - start), 128'd32);
    check("t1_fips_ct", aes128(ifc.key, ifc.data), C1);
    consume("t1", 0);

    // 2: same vector with random input gaps
    send_block(K1, D1, 1'b1, 1'b1);
    check("t2_fips_ct", aes128(ifc.key, ifc.data), C1);
    consume("t2", 3);

    // 3: out_ready held low for 10 cycles
    k2 = rand128(); d2 = rand128();
    send_block(k2, d2, 1'b1, 1'b0);
    consume("t3", 10);

    // 4: abort coincident with the 7th data byte
    d2b = d2;
    k3 = rand128(); d3 = rand128();
    kb = k3; d3b = d3;
    for (int i = 0; i < 16; i++) send_byte(kb[i], 1'b0);
    for (int i = 0; i < 6; i++) send_byte(d3b[i], 1'b0);
    ifc.in_valid = 1'b1; ifc.in_byte = ~d2b[6]; ifc.abort = 1'b1;
    @(posedge clk); #1;
    ifc.abort = 1'b0; ifc.in_valid = 1'b0;
    check("t4_ov_after_abort", 128'(ifc.out_valid), 128'd0);
    check("t4_in_ready_after_abort", 128'(ifc.in_ready), 128'd1);
    check("t4_byte_dropped", 128'(ifc.data[1][2]), 128'(d2b[6]));
    repeat (2) @(posedge clk);
    #1;
    check("t4_ov_idle", 128'(ifc.out_valid), 128'd0);
    d4 = rand128();
`ifdef KEY_REUSE_EN
    send_block(k3, d4, 1'b0, 1'b0);
`else
    k4 = rand128();
    kb = k4;
    e.key = k4; e.data = d4;
    sb.push_back(e);
    for (int i = 0; i < 16; i++) send_byte(kb[i], 1'b0);
    check("t4_no_ov_after_key", 128'(ifc.out_valid), 128'd0);
    db = d4;
    for (int i = 0; i < 16; i++) send_byte(db[i], 1'b0);
`endif
    consume("t4", 0);

    // 5: reset pulse while presenting
    k5 = rand128(); d5 = rand128();
    send_block(k5, d5, 1'b1, 1'b0);
    wait_present("t5");
    #3 rst_n = 1'b0;
    #1;
    check("t5_ov_async", 128'(ifc.out_valid), 128'd0);
    check("t5_key_zero", ifc.key, 128'd0);
    check("t5_data_zero", ifc.data, 128'd0);
    check("t5_in_ready", 128'(ifc.in_ready), 128'd1);
    if (sb.size() != 0) void'(sb.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1;
    k6 = rand128(); d6 = rand128();
    kb = k6; db = d6;
    e.key = k6; e.data = d6;
    sb.push_back(e);
    for (int i = 0; i < 16; i++) send_byte(kb[i], 1'b0);
    check("t5_no_ov_after_key", 128'(ifc.out_valid), 128'd0);
    for (int i = 0; i < 16; i++) send_byte(db[i], 1'b0);
    consume("t5", 1);

`ifdef KEY_REUSE_EN
    // 6: one key, two blocks
    send_block(K1, D1, 1'b1, 1'b0);
    check("t6_ct1", aes128(ifc.key, ifc.data), C1);
    consume("t6a", 0);
    d6 = rand128();
    send_block(K1, d6, 1'b0, 1'b0);
    check("t6_ct2", aes128(ifc.key, ifc.data), aes128(K1, d6));
    consume("t6b", 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
